// File: rtl/gsensor_spi_reader_if.sv
// ----------------------------------------------------------------------------
// gsensor_spi_reader_if
// Bundles the ADXL345 SPI pins and the sample publication bus of
// gsensor_spi_reader.
//   gsensor_cs_   chip select, active low          (master -> slave)
//   gsensor_sclk  SPI clock, idles high            (master -> slave)
//   sdi_o         MOSI                             (master -> slave)
//   sdo_i         MISO, asynchronous to clk        (slave  -> master)
//   x, y, z       signed samples {DATAn1,DATAn0}   (master -> consumer)
//   valid         one-cycle sample strobe          (master -> consumer)
//   busy          transfer or configuration active (master -> consumer)
// ----------------------------------------------------------------------------
interface gsensor_spi_reader_if;
   logic        gsensor_cs_;
   logic        gsensor_sclk;
   logic        sdi_o;
   logic        sdo_i;
   logic [15:0] x;
   logic [15:0] y;
   logic [15:0] z;
   logic        valid;
   logic        busy;

   modport master (
      output gsensor_cs_, gsensor_sclk, sdi_o, x, y, z, valid, busy,
      input  sdo_i
   );

   modport slave (
      input  gsensor_cs_, gsensor_sclk, sdi_o, x, y, z, valid, busy,
      output sdo_i
   );
endinterface

// File: rtl/gsensor_spi_reader.sv
// ----------------------------------------------------------------------------
// gsensor_spi_reader
// SPI mode-3 master that configures an ADXL345 (DATA_FORMAT, then POWER_CTL)
// and afterwards reads X/Y/Z every SAMPLE_DIV clk cycles with a multi-byte
// read starting at register 0x32.
// Ports:
//   clk    system clock
//   rst_   asynchronous active-low reset
//   en     enable periodic sampling (configuration runs regardless)
//   bus    gsensor_spi_reader_if.master: SPI pins, x/y/z, valid, busy
// ----------------------------------------------------------------------------
module gsensor_spi_reader #(
   parameter int unsigned CLK_DIV         = 25,
   parameter int unsigned SAMPLE_DIV      = 500000,
   parameter logic [7:0]  DATA_FORMAT_VAL = 8'h08,
   parameter logic [7:0]  POWER_CTL_VAL   = 8'h08
) (
   input  logic                   clk,
   input  logic                   rst_,
   input  logic                   en,
   gsensor_spi_reader_if.master   bus
);

   localparam int unsigned DW = $clog2(2 * CLK_DIV);
   localparam int unsigned SW = $clog2(SAMPLE_DIV);

   localparam logic [DW-1:0] HALF_LAST   = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] GAP_LAST    = DW'(2 * CLK_DIV - 1);
   localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_DIV - 1);

   // Top-level sequencing
   localparam logic [1:0] ST_CFG_FMT = 2'd0;
   localparam logic [1:0] ST_CFG_PWR = 2'd1;
   localparam logic [1:0] ST_WAIT    = 2'd2;
   localparam logic [1:0] ST_READ    = 2'd3;

   // Transfer engine phases
   localparam logic [2:0] PH_GAP   = 3'd0;  // cs_ high recovery time
   localparam logic [2:0] PH_IDLE  = 3'd1;  // ready to start a transfer
   localparam logic [2:0] PH_SETUP = 3'd2;  // cs_ low, sclk high before bit 0
   localparam logic [2:0] PH_LOW   = 3'd3;
   localparam logic [2:0] PH_HIGH  = 3'd4;
   localparam logic [2:0] PH_HOLD  = 3'd5;  // sclk high after last bit

   logic [1:0]    state_q,  state_d;
   logic [2:0]    phase_q,  phase_d;
   logic [DW-1:0] div_q,    div_d;
   logic [5:0]    bit_q,    bit_d;
   logic [55:0]   tx_q,     tx_d;
   logic [47:0]   rx_q,     rx_d;
   logic [SW-1:0] cnt_q,    cnt_d;
   logic          sdo_s1_q, sdo_s1_d;
   logic          sdo_s2_q, sdo_s2_d;
   logic          cs_q,     cs_d;
   logic          sclk_q,   sclk_d;
   logic          sdi_q,    sdi_d;
   logic [15:0]   x_q,      x_d;
   logic [15:0]   y_q,      y_d;
   logic [15:0]   z_q,      z_d;
   logic          valid_q,  valid_d;
   logic          busy_q,   busy_d;

   logic          start_s;
   logic [55:0]   load_s;
   logic          is_last_s;

   // Next-state logic for sequencing, transfer engine, sampling and outputs
   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      div_d     = div_q;
      bit_d     = bit_q;
      tx_d      = tx_q;
      rx_d      = rx_q;
      cnt_d     = cnt_q;
      cs_d      = cs_q;
      sclk_d    = sclk_q;
      sdi_d     = sdi_q;
      x_d       = x_q;
      y_d       = y_q;
      z_d       = z_q;
      valid_d   = 1'b0;
      sdo_s1_d  = bus.sdo_i;
      sdo_s2_d  = sdo_s1_q;
      start_s   = 1'b0;
      load_s    = 56'h0;
      is_last_s = (bit_q == ((state_q == ST_READ) ? 6'd55 : 6'd15));

      // The sample counter keeps running through READ so read starts stay
      // exactly SAMPLE_DIV apart; en=0 freezes it wherever it is.
      if (((state_q == ST_WAIT) || (state_q == ST_READ)) && en && (cnt_q != SAMPLE_LAST)) begin
         cnt_d = cnt_q + SW'(1);
      end else begin
         cnt_d = cnt_q;
      end

      case (phase_q)
         PH_GAP: begin
            if (div_q == GAP_LAST) begin
               div_d   = '0;
               phase_d = PH_IDLE;
            end else begin
               div_d = div_q + DW'(1);
            end
         end

         PH_IDLE: begin
            case (state_q)
               ST_CFG_FMT: begin
                  start_s = 1'b1;
                  load_s  = {8'h31, DATA_FORMAT_VAL, 40'h0};
               end
               ST_CFG_PWR: begin
                  start_s = 1'b1;
                  load_s  = {8'h2D, POWER_CTL_VAL, 40'h0};
               end
               ST_WAIT: begin
                  if (en && (cnt_q == SAMPLE_LAST)) begin
                     start_s = 1'b1;
                     load_s  = {8'hF2, 48'h0};
                     state_d = ST_READ;
                     cnt_d   = '0;
                  end else begin
                     start_s = 1'b0;
                  end
               end
               default: begin
                  // READ without an active transfer cannot occur; recover.
                  state_d = ST_WAIT;
               end
            endcase
         end

         PH_SETUP: begin
            if (div_q == HALF_LAST) begin
               div_d   = '0;
               phase_d = PH_LOW;
               sclk_d  = 1'b0;
               sdi_d   = tx_q[55];
               tx_d    = {tx_q[54:0], 1'b0};
            end else begin
               div_d = div_q + DW'(1);
            end
         end

         PH_LOW: begin
            if (div_q == HALF_LAST) begin
               div_d   = '0;
               phase_d = PH_HIGH;
               sclk_d  = 1'b1;
            end else begin
               div_d = div_q + DW'(1);
            end
         end

         PH_HIGH: begin
            if (div_q == HALF_LAST) begin
               div_d = '0;
               // Byte 0 of a read simply falls off the top of rx_q.
               rx_d  = {rx_q[46:0], sdo_s2_q};
               if (is_last_s) begin
                  phase_d = PH_HOLD;
               end else begin
                  bit_d   = bit_q + 6'd1;
                  phase_d = PH_LOW;
                  sclk_d  = 1'b0;
                  sdi_d   = tx_q[55];
                  tx_d    = {tx_q[54:0], 1'b0};
               end
            end else begin
               div_d = div_q + DW'(1);
            end
         end

         PH_HOLD: begin
            // First hold cycle is the cycle after the last capture.
            if ((div_q == '0) && (state_q == ST_READ)) begin
               x_d     = {rx_q[39:32], rx_q[47:40]};
               y_d     = {rx_q[23:16], rx_q[31:24]};
               z_d     = {rx_q[7:0],   rx_q[15:8]};
               valid_d = 1'b1;
               state_d = ST_WAIT;
            end else begin
               valid_d = 1'b0;
            end
            if (div_q == HALF_LAST) begin
               div_d   = '0;
               phase_d = PH_GAP;
               cs_d    = 1'b1;
               sdi_d   = 1'b0;
               case (state_q)
                  ST_CFG_FMT: state_d = ST_CFG_PWR;
                  ST_CFG_PWR: begin
                     state_d = ST_WAIT;
                     cnt_d   = '0;
                  end
                  default:    state_d = ST_WAIT;
               endcase
            end else begin
               div_d = div_q + DW'(1);
            end
         end

         default: begin
            phase_d = PH_GAP;
            div_d   = '0;
            cs_d    = 1'b1;
            sclk_d  = 1'b1;
            sdi_d   = 1'b0;
         end
      endcase

      if (start_s) begin
         tx_d    = load_s;
         cs_d    = 1'b0;
         sclk_d  = 1'b1;
         div_d   = '0;
         bit_d   = 6'd0;
         phase_d = PH_SETUP;
      end else begin
         tx_d = tx_d;
      end

      busy_d = (state_d == ST_CFG_FMT) || (state_d == ST_CFG_PWR) || !cs_d;
   end

   // State and output registers; reset aborts any transfer immediately
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q  <= ST_CFG_FMT;
         phase_q  <= PH_GAP;
         div_q    <= '0;
         bit_q    <= 6'd0;
         tx_q     <= 56'h0;
         rx_q     <= 48'h0;
         cnt_q    <= '0;
         sdo_s1_q <= 1'b0;
         sdo_s2_q <= 1'b0;
         cs_q     <= 1'b1;
         sclk_q   <= 1'b1;
         sdi_q    <= 1'b0;
         x_q      <= 16'h0;
         y_q      <= 16'h0;
         z_q      <= 16'h0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
         tx_q     <= tx_d;
         rx_q     <= rx_d;
         cnt_q    <= cnt_d;
         sdo_s1_q <= sdo_s1_d;
         sdo_s2_q <= sdo_s2_d;
         cs_q     <= cs_d;
         sclk_q   <= sclk_d;
         sdi_q    <= sdi_d;
         x_q      <= x_d;
         y_q      <= y_d;
         z_q      <= z_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.gsensor_cs_  = cs_q;
   assign bus.gsensor_sclk = sclk_q;
   assign bus.sdi_o        = sdi_q;
   assign bus.x            = x_q;
   assign bus.y            = y_q;
   assign bus.z            = z_q;
   assign bus.valid        = valid_q;
   assign bus.busy         = busy_q;

endmodule

// File: tb/tb_gsensor_spi_reader.sv
// ----------------------------------------------------------------------------
// tb_gsensor_spi_reader
// Directed bench for gsensor_spi_reader (CLK_DIV=4, SAMPLE_DIV=2000) with a
// behavioural ADXL345 SPI slave recording each cs_ window.
// ----------------------------------------------------------------------------
module tb_gsensor_spi_reader;
   localparam longint CYC = 10;

   logic clk = 1'b0;
   logic rst_;
   logic en;
   int   checks = 0;
   int   errors = 0;

   gsensor_spi_reader_if gs();

   gsensor_spi_reader #(
      .CLK_DIV(4), .SAMPLE_DIV(2000),
      .DATA_FORMAT_VAL(8'h08), .POWER_CTL_VAL(8'h08)
   ) dut (
      .clk(clk), .rst_(rst_), .en(en), .bus(gs.master)
   );

   always #5 clk = ~clk;

   // ---------------- ADXL345 slave model ----------------
   logic        cs_prev = 1'b1;
   logic        sclk_prev = 1'b1;
   logic        miso_r = 1'b0;
   logic [55:0] miso_stream = 56'h0;
   logic [55:0] mosi_sh = 56'h0;
   logic [55:0] last_mosi = 56'h0;
   int          edge_cnt = 0;
   int          last_edges = 0;
   int          miso_idx = 0;
   int          win_cnt = 0;
   int          fall_cnt = 0;
   longint      fall_t = 0;
   longint      rise_t = 0;
   longint      last_rise = 0;
   longint      per_min = 0;
   longint      per_max = 0;
   longint      last_per_min = 0;
   longint      last_per_max = 0;
   logic        sclk_at_fall = 1'b0;
   logic        sclk_at_rise = 1'b0;

   assign gs.sdo_i = miso_r;

   always @(gs.gsensor_cs_ or gs.gsensor_sclk) begin
      if (gs.gsensor_cs_ !== cs_prev) begin
         if (gs.gsensor_cs_ === 1'b0) begin
            edge_cnt     = 0;
            mosi_sh      = 56'h0;
            miso_idx     = 0;
            per_min      = 64'd1000000000;
            per_max      = 0;
            fall_t       = $time;
            sclk_at_fall = gs.gsensor_sclk;
            fall_cnt++;
         end else begin
            last_edges   = edge_cnt;
            last_mosi    = mosi_sh;
            last_per_min = per_min;
            last_per_max = per_max;
            rise_t       = $time;
            sclk_at_rise = gs.gsensor_sclk;
            miso_r       = 1'b0;
            win_cnt++;
         end
      end else if ((gs.gsensor_sclk !== sclk_prev) && (gs.gsensor_cs_ === 1'b0)) begin
         if (gs.gsensor_sclk === 1'b1) begin
            if (edge_cnt > 0) begin
               if ($time - last_rise < per_min) per_min = $time - last_rise;
               if ($time - last_rise > per_max) per_max = $time - last_rise;
            end
            last_rise = $time;
            mosi_sh   = {mosi_sh[54:0], gs.sdi_o};
            edge_cnt++;
         end else begin
            if (miso_idx < 56) miso_r = miso_stream[55 - miso_idx];
            miso_idx++;
         end
      end
      cs_prev   = gs.gsensor_cs_;
      sclk_prev = gs.gsensor_sclk;
   end

   // ---------------- valid monitor ----------------
   int          valid_cnt = 0;
   logic [15:0] cap_x = 16'h0;
   logic [15:0] cap_y = 16'h0;
   logic [15:0] cap_z = 16'h0;

   always @(negedge clk) begin
      if (gs.valid === 1'b1) begin
         valid_cnt++;
         cap_x = gs.x;
         cap_y = gs.y;
         cap_z = gs.z;
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_window(input string tag, input int budget);
      int start;
      int n;
      start = win_cnt;
      n = 0;
      while ((win_cnt == start) && (n < budget)) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_done"}, 64'(win_cnt != start), 64'd1);
   endtask

   task automatic wait_cs_fall(input string tag, input int budget);
      int start;
      int n;
      start = fall_cnt;
      n = 0;
      while ((fall_cnt == start) && (n < budget)) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_fall"}, 64'(fall_cnt != start), 64'd1);
   endtask

   task automatic wait_edges(input string tag, input int target, input int budget);
      int n;
      n = 0;
      while ((edge_cnt < target) && (n < budget)) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_edges"}, 64'(edge_cnt >= target), 64'd1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      longint pwr_end;
      longint t_r1;
      int     vc0;
      int     fc0;

      rst_ = 1'b0;
      en   = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("rst_cs",    64'(gs.gsensor_cs_),  64'd1);
      chk("rst_sclk",  64'(gs.gsensor_sclk), 64'd1);
      chk("rst_sdi",   64'(gs.sdi_o),        64'd0);
      chk("rst_valid", 64'(gs.valid),        64'd0);
      chk("rst_x",     64'(gs.x),            64'h0);
      chk("rst_y",     64'(gs.y),            64'h0);
      chk("rst_z",     64'(gs.z),            64'h0);
      chk("rst_busy",  64'(gs.busy),         64'd1);

      // Configuration writes
      @(negedge clk);
      rst_ = 1'b1;
      en   = 1'b1;
      wait_window("fmt", 300);
      chk("fmt_edges", 64'(last_edges),      64'd16);
      chk("fmt_mosi",  64'(last_mosi[15:0]), 64'h3108);
      chk("fmt_busy",  64'(gs.busy),         64'd1);
      wait_window("pwr", 300);
      pwr_end = rise_t;
      chk("pwr_edges", 64'(last_edges),      64'd16);
      chk("pwr_mosi",  64'(last_mosi[15:0]), 64'h2D08);
      chk("pwr_busy",  64'(gs.busy),         64'd0);

      // First read: 34 12 FE FF 00 80
      miso_stream = {8'h00, 48'h3412_FEFF_0080};
      vc0 = valid_cnt;
      wait_window("read1", 3000);
      t_r1 = fall_t;
      chk("r1_edges",    64'(last_edges),       64'd56);
      chk("r1_cmd",      64'(last_mosi[55:48]), 64'hF2);
      chk("r1_pad",      64'(last_mosi[47:0]),  64'h0);
      chk("r1_delay",    64'(fall_t - pwr_end), 64'(2000 * CYC));
      chk("r1_per_min",  64'(last_per_min),     64'(8 * CYC));
      chk("r1_per_max",  64'(last_per_max),     64'(8 * CYC));
      chk("r1_idle_f",   64'(sclk_at_fall),     64'd1);
      chk("r1_idle_r",   64'(sclk_at_rise),     64'd1);
      chk("r1_valid",    64'(valid_cnt - vc0),  64'd1);
      chk("r1_x",        64'(cap_x),            64'h1234);
      chk("r1_y",        64'(cap_y),            64'hFFFE);
      chk("r1_z",        64'(cap_z),            64'h8000);
      chk("r1_sdi_idle", 64'(gs.sdi_o),         64'd0);
      chk("r1_busy",     64'(gs.busy),          64'd0);

      // Second read, spacing and other data
      miso_stream = {8'h00, 48'h0100_FF7F_80FF};
      vc0 = valid_cnt;
      wait_window("read2", 3000);
      chk("r2_spacing", 64'(fall_t - t_r1),   64'(2000 * CYC));
      chk("r2_valid",   64'(valid_cnt - vc0), 64'd1);
      chk("r2_x",       64'(cap_x),           64'h0001);
      chk("r2_y",       64'(cap_y),           64'h7FFF);
      chk("r2_z",       64'(cap_z),           64'hFF80);

      // en drops during byte 3 of a read
      miso_stream = {8'h00, 48'hCDAB_3412_7856};
      vc0 = valid_cnt;
      wait_cs_fall("read3", 3000);
      wait_edges("read3", 28, 400);
      @(negedge clk);
      en = 1'b0;
      wait_window("read3", 600);
      chk("r3_edges", 64'(last_edges),      64'd56);
      chk("r3_valid", 64'(valid_cnt - vc0), 64'd1);
      chk("r3_x",     64'(cap_x),           64'hABCD);
      chk("r3_y",     64'(cap_y),           64'h1234);
      chk("r3_z",     64'(cap_z),           64'h5678);
      fc0 = fall_cnt;
      repeat (10000) @(posedge clk);
      #1;
      chk("hold_no_cs", 64'(fall_cnt - fc0), 64'd0);
      chk("hold_busy",  64'(gs.busy),        64'd0);

      // Resume: next window is a read, not a configuration write
      miso_stream = {8'h00, 48'h0000_0000_0100};
      vc0 = valid_cnt;
      @(negedge clk);
      en = 1'b1;
      wait_window("read4", 3000);
      chk("r4_edges", 64'(last_edges),       64'd56);
      chk("r4_cmd",   64'(last_mosi[55:48]), 64'hF2);
      chk("r4_valid", 64'(valid_cnt - vc0),  64'd1);
      chk("r4_z",     64'(cap_z),            64'h0001);

      // Asynchronous reset in the middle of a read
      miso_stream = {8'h00, 48'h1111_2222_3333};
      vc0 = valid_cnt;
      wait_cs_fall("read5", 3000);
      wait_edges("read5", 20, 400);
      @(posedge clk);
      #3;
      rst_ = 1'b0;
      #1;
      chk("arst_cs",   64'(gs.gsensor_cs_),  64'd1);
      chk("arst_sclk", 64'(gs.gsensor_sclk), 64'd1);
      chk("arst_busy", 64'(gs.busy),         64'd1);
      repeat (3) @(negedge clk);
      rst_ = 1'b1;
      wait_window("refmt", 300);
      chk("refmt_edges", 64'(last_edges),      64'd16);
      chk("refmt_mosi",  64'(last_mosi[15:0]), 64'h3108);
      wait_window("repwr", 300);
      chk("repwr_mosi",  64'(last_mosi[15:0]), 64'h2D08);
      chk("arst_novalid", 64'(valid_cnt - vc0), 64'd0);
      miso_stream = {8'h00, 48'h7856_3412_CDAB};
      wait_window("read6", 3000);
      chk("r6_edges", 64'(last_edges),      64'd56);
      chk("r6_valid", 64'(valid_cnt - vc0), 64'd1);
      chk("r6_x",     64'(cap_x),           64'h5678);
      chk("r6_y",     64'(cap_y),           64'h1234);
      chk("r6_z",     64'(cap_z),           64'hABCD);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
